// File: rtl/regfile_sched_pkg.sv
// Shared types and sizing for the register-file write scheduler.
package regfile_sched_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 8;

    localparam int unsigned REQ_A = 0;
    localparam int unsigned REQ_B = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves when both requesters compete.
module rr_arb2 (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (&req) begin
                gnt = ptr ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ptr <= 1'b0;
        end else if (enable && (&req)) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/regfile_write_sched.sv
// Write-port scheduler for the 8x8 register file: arbitrates A/B writes and
// runs the clear sequence, presenting registered WRITE/INADDRESS/IN to reg_file.
module regfile_write_sched #(
    parameter int unsigned DATA_W   = regfile_sched_pkg::DATA_W,
    parameter int unsigned ADDR_W   = regfile_sched_pkg::ADDR_W,
    parameter int unsigned NUM_REGS = regfile_sched_pkg::NUM_REGS
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              A_VALID,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_DATA,
    output logic              A_READY,
    input  logic              B_VALID,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_DATA,
    output logic              B_READY,
    input  logic              CLEAR_REQ,
    output logic              BUSY,
    output logic              WRITE,
    output logic [ADDR_W-1:0] INADDRESS,
    output logic [DATA_W-1:0] IN
);

    import regfile_sched_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_next;
    logic              write_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] data_next;
    logic              busy_next;
    logic              arb_en;
    logic [1:0]        req;
    logic [1:0]        gnt;

    // Clear requests pre-empt A/B in the cycle they are seen.
    assign arb_en  = (state == IDLE) && !CLEAR_REQ;
    assign req     = {B_VALID, A_VALID};
    assign A_READY = gnt[REQ_A];
    assign B_READY = gnt[REQ_B];

    rr_arb2 u_arb (
        .CLK    (CLK),
        .RESET  (RESET),
        .req    (req),
        .enable (arb_en),
        .gnt    (gnt)
    );

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        write_next   = 1'b0;
        addr_next    = INADDRESS;
        data_next    = IN;
        case (state)
            IDLE: begin
                if (CLEAR_REQ) begin
                    state_next = CLEAR;
                end else if (gnt[REQ_A]) begin
                    write_next = 1'b1;
                    addr_next  = A_ADDR;
                    data_next  = A_DATA;
                end else if (gnt[REQ_B]) begin
                    write_next = 1'b1;
                    addr_next  = B_ADDR;
                    data_next  = B_DATA;
                end
            end
            CLEAR: begin
                write_next = 1'b1;
                addr_next  = clr_cnt;
                data_next  = '0;
                if (clr_cnt == LAST_IDX) begin
                    state_next   = IDLE;
                    clr_cnt_next = '0;
                end else begin
                    clr_cnt_next = clr_cnt + ADDR_W'(1);
                end
            end
            default: begin
                state_next   = IDLE;
                clr_cnt_next = '0;
            end
        endcase
        // BUSY tracks the CLEAR state so it falls exactly when A/B may be granted again.
        busy_next = (state_next == CLEAR);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            clr_cnt   <= '0;
            WRITE     <= 1'b0;
            INADDRESS <= '0;
            IN        <= '0;
            BUSY      <= 1'b0;
        end else begin
            state     <= state_next;
            clr_cnt   <= clr_cnt_next;
            WRITE     <= write_next;
            INADDRESS <= addr_next;
            IN        <= data_next;
            BUSY      <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed bench for regfile_write_sched with a behavioural register file behind it.
module tb_regfile_write_sched;

    logic       CLK;
    logic       RESET;
    logic       A_VALID;
    logic [2:0] A_ADDR;
    logic [7:0] A_DATA;
    logic       A_READY;
    logic       B_VALID;
    logic [2:0] B_ADDR;
    logic [7:0] B_DATA;
    logic       B_READY;
    logic       CLEAR_REQ;
    logic       BUSY;
    logic       WRITE;
    logic [2:0] INADDRESS;
    logic [7:0] IN;

    logic [7:0] mem [8];

    int checks = 0;
    int errors = 0;

    regfile_write_sched dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .A_VALID   (A_VALID),
        .A_ADDR    (A_ADDR),
        .A_DATA    (A_DATA),
        .A_READY   (A_READY),
        .B_VALID   (B_VALID),
        .B_ADDR    (B_ADDR),
        .B_DATA    (B_DATA),
        .B_READY   (B_READY),
        .CLEAR_REQ (CLEAR_REQ),
        .BUSY      (BUSY),
        .WRITE     (WRITE),
        .INADDRESS (INADDRESS),
        .IN        (IN)
    );

    // Clock starts high so the first rising edge is at t=10 and t=5 falls between edges.
    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    // Stand-in for reg_file: not affected by RESET.
    always @(posedge CLK) begin
        if (WRITE === 1'b1) mem[INADDRESS] <= IN;
    end

    typedef struct {
        logic       av;
        logic [2:0] aa;
        logic [7:0] ad;
        logic       bv;
        logic [2:0] ba;
        logic [7:0] bd;
        logic       ar;
        logic       br;
        logic       w;
        logic [2:0] oa;
        logic [7:0] od;
        logic       rd_en;
        logic [2:0] rd_a;
        logic [7:0] rd_d;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic fill_ff();
        for (int i = 0; i < 8; i++) begin
            A_VALID = 1'b1;
            A_ADDR  = 3'(i);
            A_DATA  = 8'hFF;
            tick();
        end
        A_VALID = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        A_VALID = 0; A_ADDR = 0; A_DATA = 0;
        B_VALID = 0; B_ADDR = 0; B_DATA = 0;
        CLEAR_REQ = 0;
        RESET = 0;

        vecs[0]  = '{1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00};
        vecs[1]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 8'h5A, 1'b1, 3'd3, 8'h5A};
        vecs[2]  = '{1'b1, 3'd1, 8'h11, 1'b1, 3'd3, 8'hC3, 1'b1, 1'b0, 1'b1, 3'd1, 8'h11, 1'b0, 3'd0, 8'h00};
        vecs[3]  = '{1'b1, 3'd1, 8'h11, 1'b1, 3'd3, 8'hC3, 1'b0, 1'b1, 1'b1, 3'd3, 8'hC3, 1'b1, 3'd1, 8'h11};
        vecs[4]  = '{1'b1, 3'd1, 8'h11, 1'b1, 3'd3, 8'hC3, 1'b1, 1'b0, 1'b1, 3'd1, 8'h11, 1'b1, 3'd3, 8'hC3};
        vecs[5]  = '{1'b1, 3'd1, 8'h11, 1'b1, 3'd3, 8'hC3, 1'b0, 1'b1, 1'b1, 3'd3, 8'hC3, 1'b0, 3'd0, 8'h00};
        vecs[6]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 8'hC3, 1'b1, 3'd3, 8'hC3};
        vecs[7]  = '{1'b1, 3'd5, 8'h55, 1'b1, 3'd5, 8'hAA, 1'b1, 1'b0, 1'b1, 3'd5, 8'h55, 1'b1, 3'd1, 8'h11};
        vecs[8]  = '{1'b0, 3'd5, 8'h55, 1'b1, 3'd5, 8'hAA, 1'b0, 1'b1, 1'b1, 3'd5, 8'hAA, 1'b1, 3'd5, 8'h55};
        vecs[9]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd5, 8'hAA, 1'b1, 3'd5, 8'hAA};
        vecs[10] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h66, 1'b0, 1'b1, 1'b1, 3'd6, 8'h66, 1'b0, 3'd0, 8'h00};
        vecs[11] = '{1'b1, 3'd0, 8'h01, 1'b1, 3'd7, 8'h77, 1'b0, 1'b1, 1'b1, 3'd7, 8'h77, 1'b1, 3'd6, 8'h66};
        vecs[12] = '{1'b1, 3'd0, 8'h01, 1'b0, 3'd7, 8'h77, 1'b1, 1'b0, 1'b1, 3'd0, 8'h01, 1'b1, 3'd7, 8'h77};
        vecs[13] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h01, 1'b1, 3'd0, 8'h01};

        // Async reset asserted between edges
        #5 RESET = 1'b1;
        #1;
        chk("rst_write", 32'(WRITE), 32'd0);
        chk("rst_inaddr", 32'(INADDRESS), 32'd0);
        chk("rst_in", 32'(IN), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_a_ready", 32'(A_READY), 32'd0);
        chk("rst_b_ready", 32'(B_READY), 32'd0);
        @(posedge CLK);
        #2 RESET = 1'b0;

        // Single writes, contention, same-address serialization, pointer behaviour
        for (int v = 0; v < 14; v++) begin
            A_VALID = vecs[v].av; A_ADDR = vecs[v].aa; A_DATA = vecs[v].ad;
            B_VALID = vecs[v].bv; B_ADDR = vecs[v].ba; B_DATA = vecs[v].bd;
            #1;
            chk($sformatf("v%0d_a_ready", v), 32'(A_READY), 32'(vecs[v].ar));
            chk($sformatf("v%0d_b_ready", v), 32'(B_READY), 32'(vecs[v].br));
            tick();
            chk($sformatf("v%0d_write", v), 32'(WRITE), 32'(vecs[v].w));
            chk($sformatf("v%0d_inaddr", v), 32'(INADDRESS), 32'(vecs[v].oa));
            chk($sformatf("v%0d_in", v), 32'(IN), 32'(vecs[v].od));
            chk($sformatf("v%0d_busy", v), 32'(BUSY), 32'd0);
            if (vecs[v].rd_en) begin
                chk($sformatf("v%0d_reg%0d", v, vecs[v].rd_a), 32'(mem[vecs[v].rd_a]), 32'(vecs[v].rd_d));
            end
        end
        A_VALID = 0; B_VALID = 0;

        // Full clear sequence
        fill_ff();
        for (int r = 0; r < 8; r++) chk($sformatf("fill_reg%0d", r), 32'(mem[r]), 32'hFF);
        CLEAR_REQ = 1'b1;
        tick();
        CLEAR_REQ = 1'b0;
        chk("clr_start_busy", 32'(BUSY), 32'd1);
        chk("clr_start_write", 32'(WRITE), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("clr%0d_write", k), 32'(WRITE), 32'd1);
            chk($sformatf("clr%0d_inaddr", k), 32'(INADDRESS), 32'(k));
            chk($sformatf("clr%0d_in", k), 32'(IN), 32'd0);
            chk($sformatf("clr%0d_busy", k), 32'(BUSY), 32'(k < 7));
            chk($sformatf("clr%0d_a_ready", k), 32'(A_READY), 32'd0);
            chk($sformatf("clr%0d_b_ready", k), 32'(B_READY), 32'd0);
        end
        tick();
        chk("clr_end_write", 32'(WRITE), 32'd0);
        chk("clr_end_busy", 32'(BUSY), 32'd0);
        for (int r = 0; r < 8; r++) chk($sformatf("clr_reg%0d", r), 32'(mem[r]), 32'h00);

        // Clear wins over a simultaneous A request
        CLEAR_REQ = 1'b1;
        A_VALID = 1'b1; A_ADDR = 3'd4; A_DATA = 8'h44;
        #1;
        chk("cva_a_ready0", 32'(A_READY), 32'd0);
        tick();
        CLEAR_REQ = 1'b0;
        chk("cva_busy", 32'(BUSY), 32'd1);
        chk("cva_a_ready1", 32'(A_READY), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("cva%0d_inaddr", k), 32'(INADDRESS), 32'(k));
            chk($sformatf("cva%0d_busy", k), 32'(BUSY), 32'(k < 7));
            chk($sformatf("cva%0d_a_ready", k), 32'(A_READY), 32'(k == 7));
        end
        tick();
        A_VALID = 1'b0;
        chk("cva_write", 32'(WRITE), 32'd1);
        chk("cva_inaddr", 32'(INADDRESS), 32'd4);
        chk("cva_in", 32'(IN), 32'h44);
        tick();
        chk("cva_idle_write", 32'(WRITE), 32'd0);
        chk("cva_reg4", 32'(mem[4]), 32'h44);

        // Reset aborts a clear after three writes have landed
        fill_ff();
        CLEAR_REQ = 1'b1;
        tick();
        CLEAR_REQ = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("abort_pre_inaddr", 32'(INADDRESS), 32'd3);
        RESET = 1'b1;
        #1;
        chk("abort_write", 32'(WRITE), 32'd0);
        chk("abort_inaddr", 32'(INADDRESS), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        tick();
        tick();
        RESET = 1'b0;
        #1;
        for (int r = 0; r < 8; r++) begin
            chk($sformatf("abort_reg%0d", r), 32'(mem[r]), (r < 3) ? 32'h00 : 32'hFF);
        end
        A_VALID = 1'b1; A_ADDR = 3'd2; A_DATA = 8'h22;
        #1;
        chk("abort_idle_a_ready", 32'(A_READY), 32'd1);
        tick();
        A_VALID = 1'b0;
        chk("abort_idle_write", 32'(WRITE), 32'd1);
        chk("abort_idle_inaddr", 32'(INADDRESS), 32'd2);
        chk("abort_idle_busy", 32'(BUSY), 32'd0);
        tick();
        chk("abort_idle_reg2", 32'(mem[2]), 32'h22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
